pipe_hazard_unit: RTL
=====================

# pipe_hazard_unit

Parametrised, stateful hazard and forwarding unit for the pipelined CPU's ID stage. It replaces the combinational ID hazard logic, which depends on EXE/MEM destination inputs. The unit keeps its own shift register of in-flight destination records, NSTG deep, and selects forwarding from any stage. It stalls load-use hazards whose data is not yet available and interlocks a multi-cycle mul/div unit with a busy counter.

## Interface
Parameters:
- NSTG, 3: number of post-ID stages tracked (stage 1 = EXE … stage NSTG = last stage before register-file write); 1..7.
- LDSTG, 2: first stage at which load data is forwardable; 1..NSTG.
- MDLAT, 4: mul/div busy cycles after issue; ≥1.
- FW, $clog2(NSTG+1): forward-select width (derived).

Ports:
- clock  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  ID instruction is killed (branch/jump redirect).
- id_rs, id_rt  in  5 each  source register numbers of the ID instruction.
- id_use_rs, id_use_rt  in  1 each  instruction actually reads rs / rt.
- id_wreg  in  1  instruction writes the register file.
- id_rn  in  5  destination register.
- id_m2reg  in  1  instruction is a load.
- id_md  in  1  instruction starts a mul/div.
- id_hilo  in  1  instruction reads HI/LO (mfhi/mflo).
- nostall  out  1  0 = hold PC/IF-ID and inject a bubble.
- fwda, fwdb  out  FW each  0 = register file; k = forward from stage k.
- md_busy  out  1  mul/div in progress.
- stall_cnt  out  16  saturating stall count (HAZ_STATS_EN only).

## Operation
- State: NSTG entries {v, rn[4:0], ld}, plus a mul/div counter mdc (width covering MDLAT).
- Match at stage k: v_k & rn_k != 0 & rn_k == src.
- Forward select per source: the smallest matching k, giving the nearest producer. Value is 0 when there is no match or the source is unused.
- Load hazard: the nearest match has ld_k=1 and k < LDSTG. This sets fwd = 0 for that source and raises a stall.
- Register 0 never forwards and never stalls.
- MD hazard: (id_md | id_hilo) & md_busy.
- nostall = ~(load hazard on a used rs | load hazard on a used rt | MD hazard).
- Issue: issue = nostall & ~flush.
- Shift every clock:
  - stage1 ← issue & id_wreg ? {1, id_rn, id_m2reg} : bubble (v=0).
  - stage k+1 ← stage k.
  - Stage NSTG's record is discarded.
- Mul/div counter:
  - issue & id_md → mdc ← MDLAT.
  - Otherwise, when mdc ≠ 0 → mdc ← mdc−1.
  - md_busy = (mdc ≠ 0).
- Flush while stalled: a bubble is inserted and no mul/div is started; nostall still reflects the hazard.

## Timing
- nostall, fwda, fwdb and md_busy are combinational from ID inputs and registered state, valid in the same cycle.
- State updates on the rising clock edge.
- Reset (asynchronous, resetn=0): all v=0, mdc=0, stall_cnt=0. Outputs then read nostall=1, fwda=fwdb=0, md_busy=0.
- Reset asserted mid-stall clears all in-flight records immediately.
- Producer issued in cycle t:
  - Forwardable from stage 1 at t+1, stage k at t+k.
  - Invisible from t+NSTG+1; the register file supplies the value.
- Load followed by a dependent instruction:
  - Stalls LDSTG−1 cycles (default 1).
  - Then forwards from stage LDSTG.
- md_busy is high for exactly MDLAT cycles after the issue edge.
- A back-to-back id_md stalls until md_busy falls, then issues.

## Configuration
- HAZ_STATS_EN defined: stall_cnt increments on each cycle with nostall=0 and flush=0. It saturates at 16'hFFFF and resets to 0.
- HAZ_STATS_EN undefined: the stall_cnt port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold resetn=0 with any inputs → nostall=1, fwda=fwdb=0, md_busy=0. On release, with id_use_rs=1 and id_rs=5 and nothing issued, fwda=0.
- ALU chain:
  - Stimulus: issue add r3, then next cycle an instruction reading rs=3 and rt=3.
  - Required: fwda=fwdb=1.
  - One cycle later a reader of r3 → fwda=2; two cycles later → fwda=3; a fourth reader → 0.
- Load-use:
  - Stimulus: lw r8, then an instruction with rt=8 used.
  - Required: nostall=0 for exactly 1 cycle, then fwdb=2, nostall=1.
  - With rt unused: no stall.
- Priority and r0:
  - Stimulus: writes to r4 issued in consecutive cycles, then a reader of r4.
  - Required: fwda=1, the nearest producer.
  - A write to r0 followed by a reader of r0 → fwda=0, no stall.
- Mul/div with MDLAT=4:
  - Stimulus: issue mult, then mfhi.
  - Required: nostall=0 for 4 cycles, md_busy high for 4 cycles, then mfhi issues.
  - A flushed mult does not set md_busy.
- Flush and stats (HAZ_STATS_EN):
  - Stimulus: stalled lw-use with flush=1.
  - Required: a bubble enters stage 1 and stall_cnt is unchanged.
  - An unflushed stall increments stall_cnt by 1.
  - Forcing 65536 stall cycles leaves stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// ID-stage hazard/forwarding unit that tracks in-flight destinations itself.
// Define HAZ_STATS_EN to add the saturating stall_cnt output.
module pipe_hazard_unit #(
    parameter int NSTG  = 3,
    parameter int LDSTG = 2,
    parameter int MDLAT = 4,
    parameter int FW    = $clog2(NSTG + 1)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          flush,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wreg,
    input  logic [4:0]    id_rn,
    input  logic          id_m2reg,
    input  logic          id_md,
    input  logic          id_hilo,
    output logic          nostall,
    output logic [FW-1:0] fwda,
    output logic [FW-1:0] fwdb,
    output logic          md_busy
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);
    localparam int MDW = $clog2(MDLAT + 1);

    logic           r_v  [1:NSTG];
    logic [4:0]     r_rn [1:NSTG];
    logic           r_ld [1:NSTG];
    logic [MDW-1:0] r_mdc;

    logic           w_ld_haz_a;
    logic           w_ld_haz_b;
    logic           w_md_haz;
    logic           w_issue;

    // Scans from the oldest stage down so the nearest producer wins.
    function automatic logic [FW:0] lookup(input logic [4:0] src, input logic use_src);
        logic [FW-1:0] sel;
        logic          haz;
        sel = '0;
        haz = 1'b0;
        for (int k = NSTG; k >= 1; k--) begin
            if (r_v[k] && (r_rn[k] != 5'd0) && (r_rn[k] == src)) begin
                sel = FW'(k);
                haz = r_ld[k] && (k < LDSTG);
            end
        end
        if (!use_src) begin
            sel = '0;
            haz = 1'b0;
        end else if (haz) begin
            sel = '0;
        end
        return {haz, sel};
    endfunction

    assign {w_ld_haz_a, fwda} = lookup(id_rs, id_use_rs);
    assign {w_ld_haz_b, fwdb} = lookup(id_rt, id_use_rt);

    assign md_busy  = (r_mdc != '0);
    assign w_md_haz = (id_md | id_hilo) & md_busy;
    assign nostall  = ~(w_ld_haz_a | w_ld_haz_b | w_md_haz);
    assign w_issue  = nostall & ~flush;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 1; k <= NSTG; k++) begin
                r_v[k]  <= 1'b0;
                r_rn[k] <= 5'd0;
                r_ld[k] <= 1'b0;
            end
        end else begin
            r_v[1]  <= w_issue & id_wreg;
            r_rn[1] <= id_rn;
            r_ld[1] <= id_m2reg;
            for (int k = NSTG; k >= 2; k--) begin
                r_v[k]  <= r_v[k-1];
                r_rn[k] <= r_rn[k-1];
                r_ld[k] <= r_ld[k-1];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_mdc <= '0;
        end else if (w_issue && id_md) begin
            r_mdc <= MDW'(MDLAT);
        end else if (r_mdc != '0) begin
            r_mdc <= r_mdc - MDW'(1);
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] r_stall_cnt;

    // A flushed instruction is dead anyway, so its stall cycle is not counted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= 16'd0;
        end else if (!nostall && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif
endmodule
